// File: rtl/pwm_velocity_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_velocity_decoder_if
// Purpose  : Pin-side PWM input and decoded velocity bus of the PWM decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_velocity_decoder_if;
   logic        pwm_in;
   logic [10:0] velocity;
   logic        vel_valid;
   logic        range_err;
   logic        timeout;

   modport master (
      input  pwm_in,
      output velocity,
      output vel_valid,
      output range_err,
      output timeout
   );

   modport slave (
      output pwm_in,
      input  velocity,
      input  vel_valid,
      input  range_err,
      input  timeout
   );
endinterface
`default_nettype wire

// File: rtl/pwm_velocity_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_velocity_decoder
// Purpose  : Measures servo-style PWM high time in microseconds and decodes it
//            into an 11-bit velocity with range clamp and timeout watchdog.
//            Define PWM_AVG4_EN to output the mean of the last 4 decodes.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_velocity_decoder #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int TICK_HZ    = 1_000_000,
   parameter int MIN_US     = 1000,
   parameter int MAX_US     = 2000,
   parameter int TIMEOUT_US = 25000
) (
   input  logic                   clk,
   input  logic                   rst,
   pwm_velocity_decoder_if.master vel_bus
);

   localparam int c_TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int c_TW       = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
   localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_TICK_DIV - 1);
   localparam logic [15:0]     c_TIMEOUT   = 16'(TIMEOUT_US);

   typedef enum logic [1:0] {
      WAIT_LOW  = 2'd0,
      WAIT_RISE = 2'd1,
      MEASURE   = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_sync;
   logic            r_sync_d;
   logic [c_TW-1:0] r_tick_cnt;
   logic [15:0]     r_width, r_wd;
   logic [10:0]     r_velocity;
   logic            r_vel_valid, r_range_err, r_timeout;
   logic            w_rise, w_fall, w_tick, w_width_clr, w_update;
   logic [16:0]     w_diff;
   logic [10:0]     w_dec, w_vel_new;
   logic            w_dec_err, w_err_new;

   // Sync chain resets high so a pin already high at reset release reads as
   // "mid-pulse" and is discarded in WAIT_LOW rather than seen as a rise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync   <= 2'b11;
         r_sync_d <= 1'b1;
      end else begin
         r_sync   <= {r_sync[0], vel_bus.pwm_in};
         r_sync_d <= r_sync[1];
      end
   end

   assign w_rise = r_sync[1] & ~r_sync_d;
   assign w_fall = ~r_sync[1] & r_sync_d;
   assign w_tick = (r_tick_cnt == c_TICK_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_tick_cnt <= '0;
      else if (w_rise || w_tick)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + c_TW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= WAIT_LOW;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_width_clr = 1'b0;
      case (r_state)
         WAIT_LOW:  if (!r_sync[1]) w_state_nxt = WAIT_RISE;
         WAIT_RISE: if (w_rise) begin
                       w_state_nxt = MEASURE;
                       w_width_clr = 1'b1;
                    end
         MEASURE:   if (w_fall)
                       w_state_nxt = DONE;
                    else if (r_width == c_TIMEOUT)
                       w_state_nxt = WAIT_LOW;
         DONE:      if (w_rise) begin
                       w_state_nxt = MEASURE;
                       w_width_clr = 1'b1;
                    end else begin
                       w_state_nxt = WAIT_RISE;
                    end
         default:   w_state_nxt = WAIT_LOW;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_width <= '0;
      else if (w_width_clr)
         r_width <= '0;
      else if (r_state == MEASURE && w_tick && r_width != 16'hFFFF)
         r_width <= r_width + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_wd <= '0;
      else if (w_update)
         r_wd <= '0;
      else if (w_tick && r_wd != 16'hFFFF)
         r_wd <= r_wd + 16'd1;
   end

   always_comb begin
      w_diff    = {1'b0, r_width} - 17'(MIN_US);
      w_dec     = 11'(w_diff);
      w_dec_err = 1'b0;
      if (r_width < 16'(MIN_US)) begin
         w_dec     = '0;
         w_dec_err = 1'b1;
      end else if (r_width > 16'(MAX_US)) begin
         w_dec     = 11'(MAX_US - MIN_US);
         w_dec_err = 1'b1;
      end
   end

`ifdef PWM_AVG4_EN
   logic [10:0] r_buf [4];
   logic [1:0]  r_idx;
   logic        r_pend, r_err_pend;
   logic [12:0] w_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) r_buf[i] <= '0;
         r_idx      <= '0;
         r_pend     <= 1'b0;
         r_err_pend <= 1'b0;
      end else begin
         r_pend <= (r_state == DONE);
         if (r_state == DONE) begin
            r_buf[r_idx] <= w_dec;
            r_idx        <= r_idx + 2'd1;
            r_err_pend   <= w_dec_err;
         end
      end
   end

   assign w_sum     = 13'(r_buf[0]) + 13'(r_buf[1]) + 13'(r_buf[2]) + 13'(r_buf[3]);
   assign w_vel_new = 11'(w_sum >> 2);
   assign w_err_new = r_err_pend;
   assign w_update  = r_pend;
`else
   assign w_vel_new = w_dec;
   assign w_err_new = w_dec_err;
   assign w_update  = (r_state == DONE);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_velocity  <= '0;
         r_vel_valid <= 1'b0;
         r_range_err <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_vel_valid <= w_update;
         if (w_update) begin
            r_velocity  <= w_vel_new;
            r_range_err <= w_err_new;
            r_timeout   <= 1'b0;
         end else if (r_wd >= c_TIMEOUT) begin
            r_timeout   <= 1'b1;
         end
      end
   end

   assign vel_bus.velocity  = r_velocity;
   assign vel_bus.vel_valid = r_vel_valid;
   assign vel_bus.range_err = r_range_err;
   assign vel_bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pwm_velocity_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pwm_velocity_decoder
// Purpose  : Scoreboard bench for pwm_velocity_decoder (2 clk per us, 5 ms timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_velocity_decoder;
   localparam int CLK_HZ     = 2_000_000;
   localparam int TICK_HZ    = 1_000_000;
   localparam int TIMEOUT_US = 5000;
   localparam int CYC_PER_US = CLK_HZ / TICK_HZ;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pwm_velocity_decoder_if vif();

   pwm_velocity_decoder #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MIN_US(1000), .MAX_US(2000),
      .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .vel_bus (vif)
   );

   typedef struct packed {
      logic [10:0] vel;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_us(input int us);
      repeat (us * CYC_PER_US) @(negedge clk);
   endtask

   task automatic pulse(input int us, input int gap_us);
      @(negedge clk);
      vif.pwm_in = 1'b1;
      wait_us(us);
      vif.pwm_in = 1'b0;
      wait_us(gap_us);
   endtask

   task automatic send(input int us, input int vel, input logic err);
      exp_t e;
      e.vel = 11'(vel);
      e.err = err;
      q.push_back(e);
      pulse(us, 100);
   endtask

   // Monitor: every vel_valid pops one expectation; strobe must be 1 clk wide.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (vif.vel_valid) begin
            if (prev) check("strobe_width", 32'(prev), 32'd0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid actual=velocity %0d expected=no output", vif.velocity);
            end else begin
               e = q.pop_front();
               check("velocity",  32'(vif.velocity),  32'(e.vel));
               check("range_err", 32'(vif.range_err), 32'(e.err));
               check("timeout_on_update", 32'(vif.timeout), 32'd0);
            end
         end
         prev = vif.vel_valid;
      end
   end

   initial begin
      vif.pwm_in = 1'b0;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_velocity",  32'(vif.velocity),  32'd0);
      check("reset_vel_valid", 32'(vif.vel_valid), 32'd0);
      check("reset_range_err", 32'(vif.range_err), 32'd0);
      check("reset_timeout",   32'(vif.timeout),   32'd0);
      rst = 1'b1;
      wait_us(50);

`ifdef PWM_AVG4_EN
      send(1000,   0, 1'b0);
      send(1400, 100, 1'b0);
      send(1800, 300, 1'b0);
      send(2000, 550, 1'b0);
`else
      send(1500,  500, 1'b0);
      send(1500,  500, 1'b0);
      send( 900,    0, 1'b1);
      send(1200,  200, 1'b0);
      send(2100, 1000, 1'b1);
      send(1750,  750, 1'b0);

      // Low hold: about 4800 us, then 5200 us, since the last update.
      wait_us(4700);
      check("timeout_before", 32'(vif.timeout), 32'd0);
      wait_us(400);
      check("timeout_after",  32'(vif.timeout),  32'd1);
      check("velocity_held",  32'(vif.velocity), 32'd750);
      wait_us(800);
      send(1000, 0, 1'b0);
      check("timeout_cleared", 32'(vif.timeout), 32'd0);

      // Reset 300 us into a 1600 us pulse, released while pin still high.
      @(negedge clk);
      vif.pwm_in = 1'b1;
      wait_us(300);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midpulse_reset_velocity", 32'(vif.velocity), 32'd0);
      rst = 1'b1;
      wait_us(1300);
      vif.pwm_in = 1'b0;
      wait_us(100);
      send(1600, 600, 1'b0);
`endif

      wait_us(20);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
